cc_comparator_pipe: RTL and testbench

- Parametrised, pipelined multi-mode magnitude/equality comparator.
- Successor to the single-function combinational comparator: adds selectable relation, signed/unsigned operation, valid/ready flow control and a consecutive-match detector.
- Sits between a data producer and control logic that needs a registered decision stream plus a "condition held N times" flag.

---
 rtl/cc_comparator_pipe.sv | 177 +++++++++++++++++
 tb/tb_cc_comparator_pipe.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_comparator_pipe.sv
// Two-stage pipelined multi-mode comparator with valid/ready flow control
// and a saturating "N consecutive true results" detector on the output side.
module cc_comparator_pipe #(
    parameter int NUMBER_DATAWIDTH = 8,
    parameter int MATCH_COUNT      = 4,
    parameter int SIGNED_MODE      = 0
) (
    input  logic                        CC_COMPARATOR_CLOCK_50,
    input  logic                        CC_COMPARATOR_RESET_InLow,
    input  logic [NUMBER_DATAWIDTH-1:0] CC_COMPARATOR_dataA_InBUS,
    input  logic [NUMBER_DATAWIDTH-1:0] CC_COMPARATOR_dataB_InBUS,
    input  logic [2:0]                  CC_COMPARATOR_mode_InBUS,
    input  logic                        CC_COMPARATOR_valid_In,
    output logic                        CC_COMPARATOR_ready_Out,
    input  logic                        CC_COMPARATOR_clear_In,
    output logic                        CC_COMPARATOR_result_Out,
    output logic                        CC_COMPARATOR_equal_Out,
    output logic                        CC_COMPARATOR_valid_Out,
    input  logic                        CC_COMPARATOR_ready_In,
    output logic                        CC_COMPARATOR_hit_Out
);

    localparam int CNT_W = $clog2(MATCH_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MATCH_COUNT);

    // Flipping the MSB maps two's complement order onto unsigned order,
    // so one unsigned comparator serves both signedness settings.
    localparam logic [NUMBER_DATAWIDTH-1:0] SIGN_FLIP =
        (SIGNED_MODE != 0) ? {1'b1, {(NUMBER_DATAWIDTH-1){1'b0}}} : '0;

    localparam logic [2:0] MODE_EQ = 3'd0;
    localparam logic [2:0] MODE_NE = 3'd1;
    localparam logic [2:0] MODE_GT = 3'd2;
    localparam logic [2:0] MODE_LT = 3'd3;
    localparam logic [2:0] MODE_GE = 3'd4;
    localparam logic [2:0] MODE_LE = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HIT  = 2'd2
    } match_state_t;

    wire clk   = CC_COMPARATOR_CLOCK_50;
    wire rst_n = CC_COMPARATOR_RESET_InLow;

    // Stage 1 holds the raw operands, stage 2 the decision.
    logic                        s1_valid_reg;
    logic [NUMBER_DATAWIDTH-1:0] s1_a_reg;
    logic [NUMBER_DATAWIDTH-1:0] s1_b_reg;
    logic [2:0]                  s1_mode_reg;
    logic                        s2_valid_reg;
    logic                        s2_result_reg;
    logic                        s2_equal_reg;

    logic s1_free;
    logic s2_free;
    logic out_xfer;

    logic [NUMBER_DATAWIDTH-1:0] a_key;
    logic [NUMBER_DATAWIDTH-1:0] b_key;
    logic                        rel_eq;
    logic                        rel_gt;
    logic                        rel_lt;
    logic                        rel_result;

    match_state_t     state_reg;
    match_state_t     state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             hit;

    // A stage may take new data when it is empty or its content moves on
    // this cycle; ready therefore ripples combinationally from downstream.
    assign s2_free  = !s2_valid_reg || CC_COMPARATOR_ready_In;
    assign s1_free  = !s1_valid_reg || s2_free;
    assign out_xfer = s2_valid_reg && CC_COMPARATOR_ready_In;
    assign cnt_inc  = cnt_reg + CNT_W'(1);

    assign CC_COMPARATOR_ready_Out  = s1_free;
    assign CC_COMPARATOR_valid_Out  = s2_valid_reg;
    assign CC_COMPARATOR_result_Out = s2_result_reg;
    assign CC_COMPARATOR_equal_Out  = s2_equal_reg;
    assign CC_COMPARATOR_hit_Out    = hit;

    // Stage 1: capture operands and relation on an input transfer, hold when stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_mode_reg  <= 3'd0;
        end else if (s1_free) begin
            s1_valid_reg <= CC_COMPARATOR_valid_In;
            if (CC_COMPARATOR_valid_In) begin
                s1_a_reg    <= CC_COMPARATOR_dataA_InBUS;
                s1_b_reg    <= CC_COMPARATOR_dataB_InBUS;
                s1_mode_reg <= CC_COMPARATOR_mode_InBUS;
            end
        end
    end

    // Relation evaluation on the stage-1 operands; reserved modes yield 0.
    always_comb begin
        a_key      = s1_a_reg ^ SIGN_FLIP;
        b_key      = s1_b_reg ^ SIGN_FLIP;
        rel_eq     = (s1_a_reg == s1_b_reg);
        rel_gt     = (a_key > b_key);
        rel_lt     = (a_key < b_key);
        rel_result = 1'b0;
        case (s1_mode_reg)
            MODE_EQ: rel_result = rel_eq;
            MODE_NE: rel_result = !rel_eq;
            MODE_GT: rel_result = rel_gt;
            MODE_LT: rel_result = rel_lt;
            MODE_GE: rel_result = rel_gt || rel_eq;
            MODE_LE: rel_result = rel_lt || rel_eq;
            default: rel_result = 1'b0;
        endcase
    end

    // Stage 2: register the decision; hold it while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg  <= 1'b0;
            s2_result_reg <= 1'b0;
            s2_equal_reg  <= 1'b0;
        end else if (s2_free) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_result_reg <= rel_result;
                s2_equal_reg  <= rel_eq;
            end
        end
    end

    // Match detector state and counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Match detector next state: clear wins, otherwise advance on output transfers only.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (CC_COMPARATOR_clear_In) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else if (out_xfer) begin
            if (s2_result_reg) begin
                if (cnt_reg >= CNT_MAX) begin
                    state_next = ST_HIT;
                    cnt_next   = CNT_MAX;
                end else begin
                    cnt_next   = cnt_inc;
                    state_next = (cnt_inc == CNT_MAX) ? ST_HIT : ST_RUN;
                end
            end else begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        end
    end

    // Match detector output: hit follows the registered state.
    always_comb begin
        hit = (state_reg == ST_HIT);
    end

endmodule

// File: tb/tb_cc_comparator_pipe.sv
// Bench for cc_comparator_pipe: an unsigned and a signed instance share stimulus;
// a scoreboard queue holds expected decisions from an integer model.
module tb_cc_comparator_pipe;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] mode;
    logic       valid_in;
    logic       ready_in;
    logic       clear;

    logic ready_out_u, result_u, equal_u, valid_out_u, hit_u;
    logic ready_out_s, result_s, equal_s, valid_out_s, hit_s;

    int checks   = 0;
    int failures = 0;
    int popped   = 0;

    typedef struct {
        logic res_u;
        logic res_s;
        logic eq;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic [7:0] st_a [16];
    logic [7:0] st_b [16];
    logic [2:0] st_m [16];

    cc_comparator_pipe #(.NUMBER_DATAWIDTH(8), .MATCH_COUNT(3), .SIGNED_MODE(0)) dut_u (
        .CC_COMPARATOR_CLOCK_50    (clk),
        .CC_COMPARATOR_RESET_InLow (rst_n),
        .CC_COMPARATOR_dataA_InBUS (a),
        .CC_COMPARATOR_dataB_InBUS (b),
        .CC_COMPARATOR_mode_InBUS  (mode),
        .CC_COMPARATOR_valid_In    (valid_in),
        .CC_COMPARATOR_ready_Out   (ready_out_u),
        .CC_COMPARATOR_clear_In    (clear),
        .CC_COMPARATOR_result_Out  (result_u),
        .CC_COMPARATOR_equal_Out   (equal_u),
        .CC_COMPARATOR_valid_Out   (valid_out_u),
        .CC_COMPARATOR_ready_In    (ready_in),
        .CC_COMPARATOR_hit_Out     (hit_u)
    );

    cc_comparator_pipe #(.NUMBER_DATAWIDTH(8), .MATCH_COUNT(3), .SIGNED_MODE(1)) dut_s (
        .CC_COMPARATOR_CLOCK_50    (clk),
        .CC_COMPARATOR_RESET_InLow (rst_n),
        .CC_COMPARATOR_dataA_InBUS (a),
        .CC_COMPARATOR_dataB_InBUS (b),
        .CC_COMPARATOR_mode_InBUS  (mode),
        .CC_COMPARATOR_valid_In    (valid_in),
        .CC_COMPARATOR_ready_Out   (ready_out_s),
        .CC_COMPARATOR_clear_In    (clear),
        .CC_COMPARATOR_result_Out  (result_s),
        .CC_COMPARATOR_equal_Out   (equal_s),
        .CC_COMPARATOR_valid_Out   (valid_out_s),
        .CC_COMPARATOR_ready_In    (ready_in),
        .CC_COMPARATOR_hit_Out     (hit_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference relation using plain integer arithmetic.
    function automatic logic model_rel(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic [2:0] mm, input bit sgn);
        int ia;
        int ib;
        ia = sgn ? int'($signed(ma)) : int'(ma);
        ib = sgn ? int'($signed(mb)) : int'(mb);
        case (mm)
            3'd0:    return ia == ib;
            3'd1:    return ia != ib;
            3'd2:    return ia > ib;
            3'd3:    return ia < ib;
            3'd4:    return ia >= ib;
            3'd5:    return ia <= ib;
            default: return 1'b0;
        endcase
    endfunction

    // Scoreboard monitor, sampled on the falling edge: pop on output transfer, push on input transfer.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (valid_out_u === 1'b1 && ready_in === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_underflow got=unexpected_beat exp=no_beat");
                end else begin
                    mon_e = sb.pop_front();
                    popped++;
                    $display("out beat %0d: res_u=%0b res_s=%0b eq=%0b", popped, result_u, result_s, equal_u);
                    if ({result_u, result_s, equal_u, equal_s, valid_out_s} !==
                        {mon_e.res_u, mon_e.res_s, mon_e.eq, mon_e.eq, 1'b1}) begin
                        failures++;
                        $display("FAIL sb_beat got={res_u,res_s,eq_u,eq_s,vld_s}=%b exp=%b",
                                 {result_u, result_s, equal_u, equal_s, valid_out_s},
                                 {mon_e.res_u, mon_e.res_s, mon_e.eq, mon_e.eq, 1'b1});
                    end
                end
            end
            if (valid_in === 1'b1 && ready_out_u === 1'b1) begin
                mon_e.res_u = model_rel(a, b, mode, 1'b0);
                mon_e.res_s = model_rel(a, b, mode, 1'b1);
                mon_e.eq    = (a == b);
                sb.push_back(mon_e);
            end
        end
    end

    // Stimulus only: offer st_* beats back to back until each is accepted.
    task automatic stream_beats(input int n);
        int idx = 0;
        int guard = 0;
        while (idx < n && guard < 200) begin
            valid_in = 1'b1;
            a = st_a[idx];
            b = st_b[idx];
            mode = st_m[idx];
            #1;
            if (ready_out_u === 1'b1) idx++;
            @(posedge clk); #1;
            guard++;
        end
        valid_in = 1'b0;
        if (guard >= 200) begin
            checks++;
            failures++;
            $display("FAIL stream_timeout got=%0d exp=%0d", idx, n);
        end
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((sb.size() != 0 || valid_out_u === 1'b1) && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 100) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid_in = 1'b0; ready_in = 1'b1; clear = 1'b0;
        a = 8'd0; b = 8'd0; mode = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({result_u, equal_u, valid_out_u, hit_u, result_s, valid_out_s, hit_s} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0000000",
                     {result_u, equal_u, valid_out_u, hit_u, result_s, valid_out_s, hit_s});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_out_u !== 1'b1 || valid_out_u !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got=rdy%b vld%b exp=rdy1 vld0", ready_out_u, valid_out_u);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [7:0] ta [2] = '{8'd200, 8'd100};
        logic       tr [2] = '{1'b1, 1'b0};
        logic       te [2] = '{1'b0, 1'b1};
        ready_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            int lat = 0;
            bit seen = 0;
            a = ta[i]; b = 8'd100; mode = 3'd2; valid_in = 1'b1;
            @(negedge clk);
            checks++;
            if (ready_out_u !== 1'b1) begin
                failures++;
                $display("FAIL basic_accept got=%b exp=1", ready_out_u);
            end
            @(posedge clk); #1;
            valid_in = 1'b0;
            while (!seen && lat < 6) begin
                @(negedge clk);
                lat++;
                if (valid_out_u === 1'b1) seen = 1;
            end
            checks++;
            if (!seen || lat != 2) begin
                failures++;
                $display("FAIL basic_latency got=%0d exp=2", lat);
            end
            checks++;
            if (result_u !== tr[i] || equal_u !== te[i]) begin
                failures++;
                $display("FAIL basic_gt got=res%b eq%b exp=res%b eq%b", result_u, equal_u, tr[i], te[i]);
            end
            @(posedge clk); #1;
        end
        wait_drain();
    endtask

    task automatic test_signed();
        int g = 0;
        ready_in = 1'b1;
        a = 8'hFF; b = 8'h01; mode = 3'd3; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        while (valid_out_u !== 1'b1 && g < 10) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (result_u !== 1'b0 || result_s !== 1'b1) begin
            failures++;
            $display("FAIL signed_lt got=u%b s%b exp=u0 s1", result_u, result_s);
        end
        @(posedge clk); #1;
        wait_drain();
    endtask

    task automatic test_all_modes();
        int p0 = popped;
        ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            st_a[i] = 8'd5;
            st_b[i] = 8'd5;
            st_m[i] = 3'(i);
        end
        stream_beats(8);
        wait_drain();
        checks++;
        if (popped - p0 != 8) begin
            failures++;
            $display("FAIL modes_count got=%0d exp=8", popped - p0);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] bpa [6] = '{8'd50, 8'd10, 8'd77, 8'd200, 8'd3, 8'd128};
        logic [7:0] bpb [6] = '{8'd10, 8'd50, 8'd76, 8'd100, 8'd3, 8'd127};
        int idx = 0;
        int p0 = popped;
        ready_in = 1'b0;
        for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
            if (cyc == 4) ready_in = 1'b1;
            valid_in = 1'b1;
            a = bpa[idx]; b = bpb[idx]; mode = 3'd2;
            #1;
            if (cyc == 2 || cyc == 3) begin
                checks++;
                if (ready_out_u !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_ready_low cyc%0d got=%b exp=0", cyc, ready_out_u);
                end
            end
            if (ready_out_u === 1'b1) idx++;
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        wait_drain();
        checks++;
        if (popped - p0 != 6 || sb.size() != 0) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=6", popped - p0);
        end
    endtask

    task automatic test_match();
        // T,T,F,T,T,T,T then T with clear, then T,T,T (MATCH_COUNT = 3)
        logic seq_t [11] = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
        logic seq_c [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        logic seq_h [11] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1};
        ready_in = 1'b1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        for (int i = 0; i < 11; i++) begin
            a = 8'd9;
            b = seq_t[i] ? 8'd9 : 8'd3;
            mode = 3'd0;
            valid_in = 1'b1;
            @(posedge clk); #1;
            valid_in = 1'b0;
            @(posedge clk); #1;
            clear = seq_c[i];
            @(posedge clk); #1;
            clear = 1'b0;
            @(negedge clk);
            checks++;
            if (hit_u !== seq_h[i] || hit_s !== seq_h[i]) begin
                failures++;
                $display("FAIL match_hit beat%0d got=u%b s%b exp=%b", i + 1, hit_u, hit_s, seq_h[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midflight();
        ready_in = 1'b1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st_a[i] = 8'd42; st_b[i] = 8'd42; st_m[i] = 3'd0;
        end
        stream_beats(3);
        wait_drain();
        ready_in = 1'b0;
        stream_beats(2);
        checks++;
        if (valid_out_u !== 1'b1 || result_u !== 1'b1 || hit_u !== 1'b1) begin
            failures++;
            $display("FAIL midflight_pre got=vld%b res%b hit%b exp=vld1 res1 hit1",
                     valid_out_u, result_u, hit_u);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({valid_out_u, hit_u, result_u, equal_u, valid_out_s, hit_s} !== 6'b0) begin
            failures++;
            $display("FAIL midflight_async got=%b exp=000000",
                     {valid_out_u, hit_u, result_u, equal_u, valid_out_s, hit_s});
        end
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready_in = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_out_u !== 1'b1 || valid_out_u !== 1'b0 || hit_u !== 1'b0) begin
            failures++;
            $display("FAIL midflight_release got=rdy%b vld%b hit%b exp=rdy1 vld0 hit0",
                     ready_out_u, valid_out_u, hit_u);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_all_modes();
        test_backpressure();
        test_match();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
